// File: rtl/aes_out_serializer_if.sv
// rtl/aes_out_serializer_if.sv - block capture / word stream bundle for the AES output serializer
interface aes_out_serializer_if #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               blk_valid_in;
  logic [BLOCK_W-1:0] blk_data_in;
  logic               word_valid;
  logic [WORD_W-1:0]  word_data;
  logic               word_last;
  logic               word_ready;
  logic [CW-1:0]      fifo_count;
  logic               overflow;

  // Serializer side: takes blocks and ready, produces the word stream and status
  modport slave (
    input  blk_valid_in, blk_data_in, word_ready,
    output word_valid, word_data, word_last, fifo_count, overflow
  );

  // Environment side: supplies blocks and ready, observes the word stream
  modport master (
    output blk_valid_in, blk_data_in, word_ready,
    input  word_valid, word_data, word_last, fifo_count, overflow
  );
endinterface

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - buffers 128-bit AES results and streams them as MS-first words
module aes_out_serializer #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  aes_out_serializer_if.slave bus
);
  localparam int NW = BLOCK_W / WORD_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  logic               v_q;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [BLOCK_W-1:0] mem_q [DEPTH];

  logic               not_empty;
  logic               cap;
  logic               xfer;
  logic               pop;
  logic               accept;
  logic [BLOCK_W-1:0] head;
  logic [WORD_W-1:0]  word_mux;

  assign not_empty = (count_q != '0);
  // Rising edge of the core's valid level: one capture however long valid is held
  assign cap       = bus.blk_valid_in & ~v_q;
  assign xfer      = not_empty & bus.word_ready;
  assign pop       = xfer & (idx_q == LAST_IDX);
  // A full buffer still takes the block when the head is leaving on this same edge
  assign accept    = cap & ((count_q != FULL) | pop);
  assign head      = mem_q[rd_ptr_q];

  // Select the current word of the head block, most significant word at index 0
  always_comb begin
    word_mux = '0;
    for (int i = 0; i < NW; i++) begin
      if (idx_q == IW'(i)) begin
        word_mux = head[BLOCK_W-1-i*WORD_W -: WORD_W];
      end
    end
  end

  assign bus.word_valid = not_empty;
  assign bus.word_data  = not_empty ? word_mux : '0;
  assign bus.word_last  = not_empty & (idx_q == LAST_IDX);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

  // Next-state for pointers, word index, occupancy and the sticky drop flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (cap && !accept) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      idx_d    = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  // State registers and block storage; reset discards everything buffered
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      v_q        <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      v_q        <= bus.blk_valid_in;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= bus.blk_data_in;
      end
    end
  end
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - self-checking bench for aes_out_serializer with a block-queue model
module tb_aes_out_serializer;
  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int DEPTH   = 2;
  localparam int NW      = BLOCK_W / WORD_W;

  logic AES_clk = 1'b0;
  logic AES_rst = 1'b1;

  aes_out_serializer_if #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  aes_out_serializer #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .AES_clk (AES_clk),
    .AES_rst (AES_rst),
    .bus     (bus)
  );

  always #5 AES_clk = ~AES_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of whole blocks, position in the head block, prev valid, sticky drop
  logic [BLOCK_W-1:0] mq [$];
  int m_idx  = 0;
  bit m_prev = 1'b0;
  bit m_ovf  = 1'b0;

  int dut_max_count = 0;
  int dut_xfers     = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    m_prev = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [BLOCK_W-1:0] hd;
    logic [WORD_W-1:0]  w;
    bit v;
    v = (mq.size() != 0);
    w = '0;
    if (v) begin
      hd = mq[0];
      w  = WORD_W'(hd >> (WORD_W * (NW - 1 - m_idx)));
    end
    check("valid", 128'(bus.word_valid), 128'(v));
    check("data",  128'(bus.word_data),  128'(w));
    check("last",  128'(bus.word_last),  128'(v && (m_idx == NW - 1)));
    check("count", 128'(bus.fifo_count), 128'(mq.size()));
    check("ovf",   128'(bus.overflow),   128'(m_ovf));
    if (int'(bus.fifo_count) > dut_max_count) dut_max_count = int'(bus.fifo_count);
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance model over the next rising edge
  task automatic step(input bit v, input logic [BLOCK_W-1:0] d, input bit r);
    bit cap;
    compare_outputs();
    if (bus.word_valid && r) dut_xfers++;
    bus.blk_valid_in = v;
    bus.blk_data_in  = d;
    bus.word_ready   = r;
    if (!AES_rst) begin
      cap = v && !m_prev;
      if (mq.size() != 0 && r) begin
        if (m_idx == NW - 1) begin
          mq.delete(0);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
      m_prev = v;
    end
    @(negedge AES_clk);
  endtask

  function automatic logic [BLOCK_W-1:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [BLOCK_W-1:0] KAT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  initial begin
    logic [WORD_W-1:0] kat_words [NW];
    logic [BLOCK_W-1:0] blk_a, blk_b, blk_c;
    kat_words[0] = 32'h69c4e0d8;
    kat_words[1] = 32'h6a7b0430;
    kat_words[2] = 32'hd8cdb780;
    kat_words[3] = 32'h70b4c55a;

    bus.blk_valid_in = 1'b0;
    bus.blk_data_in  = '0;
    bus.word_ready   = 1'b0;
    model_reset();
    @(negedge AES_clk);
    step(0, '0, 0);
    step(0, '0, 0);
    AES_rst = 1'b0;
    step(0, '0, 1);

    // Single known block streamed with ready held high
    step(1, KAT, 1);
    for (int i = 0; i < NW; i++) begin
      check("kat_word", 128'(bus.word_data), 128'(kat_words[i]));
      check("kat_last", 128'(bus.word_last), 128'(i == NW - 1));
      step(0, '0, 1);
    end
    check("kat_empty", 128'(bus.fifo_count), 128'(0));

    // Valid held for 51 cycles: one capture only
    dut_max_count = 0;
    dut_xfers     = 0;
    for (int i = 0; i < 51; i++) step(1, rnd_block(), 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    check("held_maxcnt", 128'(dut_max_count), 128'(1));
    check("held_words",  128'(dut_xfers),     128'(NW));

    // Backpressure after word 1
    step(1, KAT, 1);
    step(0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_data",  128'(bus.word_data),  128'(32'h6a7b0430));
      check("bp_valid", 128'(bus.word_valid), 128'(1));
      step(0, '0, 0);
    end
    for (int i = 0; i < 5; i++) step(0, '0, 1);

    // Overflow: three captures into a stalled two-entry buffer
    blk_a = rnd_block();
    blk_b = rnd_block();
    blk_c = rnd_block();
    step(1, blk_a, 0);
    step(0, '0, 0);
    step(1, blk_b, 0);
    step(0, '0, 0);
    step(1, blk_c, 0);
    step(0, '0, 0);
    check("ovf_count", 128'(bus.fifo_count), 128'(2));
    check("ovf_flag",  128'(bus.overflow),   128'(1));
    check("ovf_head",  128'(bus.word_data),  128'(blk_a[127:96]));
    for (int i = 0; i < 5; i++) step(0, '0, 1);
    check("ovf_second", 128'(bus.word_data), 128'(blk_b[95:64]));

    // Asynchronous reset in the middle of a block
    #2 AES_rst = 1'b1;
    #1;
    check("rst_valid", 128'(bus.word_valid), 128'(0));
    check("rst_data",  128'(bus.word_data),  128'(0));
    check("rst_last",  128'(bus.word_last),  128'(0));
    check("rst_count", 128'(bus.fifo_count), 128'(0));
    check("rst_ovf",   128'(bus.overflow),   128'(0));
    model_reset();
    @(negedge AES_clk);
    step(0, '0, 1);
    AES_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Full buffer with a capture on the same edge as the head's last word
    blk_a = rnd_block();
    blk_b = rnd_block();
    blk_c = rnd_block();
    step(1, blk_a, 0);
    step(0, '0, 0);
    step(1, blk_b, 0);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    check("fp_last_pending", 128'(bus.word_last), 128'(1));
    step(1, blk_c, 1);
    check("fp_count", 128'(bus.fifo_count), 128'(2));
    check("fp_ovf",   128'(bus.overflow),   128'(0));
    check("fp_next",  128'(bus.word_data),  128'(blk_b[127:96]));
    for (int i = 0; i < NW; i++) step(0, '0, 1);
    check("fp_third", 128'(bus.word_data), 128'(blk_c[127:96]));
    for (int i = 0; i < NW; i++) step(0, '0, 1);

    // Randomized traffic against the block-queue model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), rnd_block(), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 12; i++) step(0, '0, 1);
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
